led_pattern_arbiter: RTL and testbench

Per-LED pattern controller that sits in front of the RGB PWM block and drives one LED's red/green/blue code values and brightness duty-cycle value. Three requesters (e.g. MCU command, power-fail alarm, ignition indication) compete for the LED under fixed priority. The block latches the winner's colour, brightness and pattern, then sequences it as steady, blink or fade on a slow tick. One instance is used per LED (led2, led3).

---
 rtl/led_pattern_arbiter.sv | 164 ++++++++++++++++
 tb/tb_led_pattern_arbiter.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/led_pattern_arbiter.sv
// led_pattern_arbiter
//   Fixed-priority arbiter and pattern sequencer for one RGB LED. The owner's
//   colour, brightness, mode and parameter are latched when it is granted.
//   They are then played as steady, blink or fade on a slow tick, and the
//   result feeds the PWM block.
// Ports:
//   i_clk, i_rst_n      clock, async active-low reset
//   i_req[2:0]          per-source request, bit 2 highest priority
//   i_src_rgb[71:0]     per-source {R,G,B}, source i at [24i+23:24i]
//   i_src_dc[23:0]      per-source brightness, source i at [8i+7:8i]
//   i_src_mode[5:0]     per-source mode (00 OFF, 01 STEADY, 10 BLINK, 11 FADE)
//   i_src_param[23:0]   per-source blink half-period / fade step (0 acts as 1)
//   o_grant[2:0]        one-hot owner, zero when idle
//   o_red/green/blue_value, o_dc_value  registered codes to the PWM block
module led_pattern_arbiter #(
    parameter int TICK_CLKS = 384
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [2:0]  i_req,
    input  logic [71:0] i_src_rgb,
    input  logic [23:0] i_src_dc,
    input  logic [5:0]  i_src_mode,
    input  logic [23:0] i_src_param,
    output logic [2:0]  o_grant,
    output logic [7:0]  o_red_value,
    output logic [7:0]  o_green_value,
    output logic [7:0]  o_blue_value,
    output logic [7:0]  o_dc_value
);
    localparam int CW = (TICK_CLKS > 1) ? $clog2(TICK_CLKS) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_STEADY, S_BLINK_ON, S_BLINK_OFF, S_FADE_UP, S_FADE_DOWN
    } state_t;

    typedef struct packed {
        logic [23:0] rgb;
        logic [7:0]  dc;
        logic [1:0]  mode;
        logic [7:0]  param;
    } fields_t;

    state_t        r_state, w_state_nxt;
    fields_t       r_fld, w_sel;
    logic [2:0]    r_grant, w_win;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic [7:0]    r_level, w_level_nxt;
    logic [7:0]    r_ph, w_ph_nxt;
    logic [7:0]    w_step;
    logic [8:0]    w_sum, w_dif;
    logic          w_chg, w_tick;
    logic [23:0]   w_rgb_nxt;
    logic [7:0]    w_dc_nxt;

    // The highest asserted request always wins. This covers preemption and
    // handover on a same-cycle drop without any extra owner-hold logic.
    always_comb begin
        w_win = 3'b000;
        w_sel = '{rgb: i_src_rgb[23:0], dc: i_src_dc[7:0],
                  mode: i_src_mode[1:0], param: i_src_param[7:0]};
        if (i_req[2]) begin
            w_win = 3'b100;
            w_sel = '{rgb: i_src_rgb[71:48], dc: i_src_dc[23:16],
                      mode: i_src_mode[5:4], param: i_src_param[23:16]};
        end else if (i_req[1]) begin
            w_win = 3'b010;
            w_sel = '{rgb: i_src_rgb[47:24], dc: i_src_dc[15:8],
                      mode: i_src_mode[3:2], param: i_src_param[15:8]};
        end else if (i_req[0]) begin
            w_win = 3'b001;
        end
    end

    assign w_chg  = (w_win != r_grant);
    assign w_tick = (r_cnt == CW'(TICK_CLKS - 1));
    assign w_step = (r_fld.param == 8'd0) ? 8'd1 : r_fld.param;
    // 9-bit fade arithmetic so the sum and difference saturate instead of wrapping.
    assign w_sum  = {1'b0, r_level} + {1'b0, w_step};
    assign w_dif  = {1'b0, r_level} - {1'b0, w_step};

    always_comb begin
        w_state_nxt = r_state;
        w_level_nxt = r_level;
        w_ph_nxt    = r_ph;
        w_cnt_nxt   = '0;
        if (w_chg) begin
            if (w_win == 3'b000)          w_state_nxt = S_IDLE;
            else if (w_sel.mode == 2'b10) w_state_nxt = S_BLINK_ON;
            else if (w_sel.mode == 2'b11) w_state_nxt = S_FADE_UP;
            else                          w_state_nxt = S_STEADY;
            w_level_nxt = 8'd0;
            w_ph_nxt    = 8'd0;
        end else if (r_state != S_IDLE) begin
            w_cnt_nxt = w_tick ? '0 : r_cnt + 1'b1;
            if (w_tick) begin
                case (r_state)
                    S_BLINK_ON, S_BLINK_OFF: begin
                        if (r_ph == w_step - 8'd1) begin
                            w_ph_nxt    = 8'd0;
                            w_state_nxt = (r_state == S_BLINK_ON) ? S_BLINK_OFF : S_BLINK_ON;
                        end else begin
                            w_ph_nxt = r_ph + 8'd1;
                        end
                    end
                    S_FADE_UP: begin
                        w_level_nxt = (w_sum > {1'b0, r_fld.dc}) ? r_fld.dc : w_sum[7:0];
                        if (w_level_nxt == r_fld.dc && r_fld.dc != 8'd0)
                            w_state_nxt = S_FADE_DOWN;
                    end
                    S_FADE_DOWN: begin
                        if (w_dif[8] || w_dif == 9'd0) begin
                            w_level_nxt = 8'd0;
                            w_state_nxt = S_FADE_UP;
                        end else begin
                            w_level_nxt = w_dif[7:0];
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Output codes follow the registered state, so they lag grant by one clock.
    always_comb begin
        w_rgb_nxt = r_fld.rgb;
        w_dc_nxt  = 8'd0;
        case (r_state)
            S_IDLE:      w_rgb_nxt = 24'd0;
            S_STEADY:    w_dc_nxt  = (r_fld.mode == 2'b01) ? r_fld.dc : 8'd0;
            S_BLINK_ON:  w_dc_nxt  = r_fld.dc;
            S_FADE_UP,
            S_FADE_DOWN: w_dc_nxt  = r_level;
            default:     w_dc_nxt  = 8'd0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= S_IDLE;
            r_grant       <= 3'b000;
            r_fld         <= '0;
            r_cnt         <= '0;
            r_level       <= 8'd0;
            r_ph          <= 8'd0;
            o_red_value   <= 8'd0;
            o_green_value <= 8'd0;
            o_blue_value  <= 8'd0;
            o_dc_value    <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_win;
            if (w_chg) r_fld <= w_sel;
            r_cnt   <= w_cnt_nxt;
            r_level <= w_level_nxt;
            r_ph    <= w_ph_nxt;
            {o_red_value, o_green_value, o_blue_value} <= w_rgb_nxt;
            o_dc_value <= w_dc_nxt;
        end
    end

    assign o_grant = r_grant;
endmodule

// File: tb/tb_led_pattern_arbiter.sv
module tb_led_pattern_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  req = '0;
    logic [71:0] src_rgb = '0;
    logic [23:0] src_dc = '0;
    logic [5:0]  src_mode = '0;
    logic [23:0] src_param = '0;
    logic [2:0]  grant;
    logic [7:0]  red, green, blue, dc;
    int          n_chk = 0;
    int          n_err = 0;

    led_pattern_arbiter #(.TICK_CLKS(4)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_src_rgb(src_rgb),
        .i_src_dc(src_dc), .i_src_mode(src_mode), .i_src_param(src_param),
        .o_grant(grant), .o_red_value(red), .o_green_value(green),
        .o_blue_value(blue), .o_dc_value(dc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_src(input int i, input logic [23:0] rgb, input logic [7:0] d,
                           input logic [1:0] m, input logic [7:0] p);
        src_rgb[24*i +: 24] = rgb;
        src_dc[8*i +: 8]    = d;
        src_mode[2*i +: 2]  = m;
        src_param[8*i +: 8] = p;
    endtask

    task automatic nclk(input int n);
        repeat (n) @(negedge clk);
    endtask

    logic [7:0] fade_exp [8] = '{8'h00, 8'h04, 8'h08, 8'h0A, 8'h06, 8'h02, 8'h00, 8'h04};

    initial begin
        // reset state
        nclk(2);
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_out", {red, green, blue, dc}, 32'h0);
        rst_n = 1'b1;
        nclk(1);

        // steady, latency 1 / 2 clocks
        set_src(0, 24'hFF8000, 8'hC0, 2'b01, 8'h00);
        req = 3'b001;
        nclk(1);
        chk("st_grant", 32'(grant), 32'h1);
        chk("st_out_lag", {red, green, blue, dc}, 32'h0);
        nclk(1);
        chk("st_out", {red, green, blue, dc}, 32'hFF80_00C0);
        req = 3'b000;
        nclk(1);
        chk("st_drop_grant", 32'(grant), 32'h0);
        chk("st_drop_lag", 32'(dc), 32'hC0);
        nclk(1);
        chk("st_drop_out", {red, green, blue, dc}, 32'h0);

        // blink: param 2, TICK 4 -> 8 clocks on, 8 off
        set_src(0, 24'h123456, 8'h40, 2'b10, 8'h02);
        req = 3'b001;
        nclk(1);
        chk("bl_grant", 32'(grant), 32'h1);
        for (int k = 2; k <= 18; k++) begin
            nclk(1);
            chk($sformatf("bl_dc%0d", k), 32'(dc), (((k - 2) / 8) % 2 == 0) ? 32'h40 : 32'h0);
            chk($sformatf("bl_rgb%0d", k), 32'({red, green, blue}), 32'h123456);
        end

        // preempt by src2, then src0 re-granted in BLINK_ON
        set_src(2, 24'h0000FF, 8'hFF, 2'b01, 8'h00);
        req = 3'b101;
        nclk(1);
        chk("pre_grant", 32'(grant), 32'h4);
        nclk(1);
        chk("pre_out", {red, green, blue, dc}, 32'h0000_FFFF);
        req = 3'b001;
        nclk(1);
        chk("reg_grant", 32'(grant), 32'h1);
        nclk(1);
        chk("reg_on", {red, green, blue, dc}, 32'h1234_5640);
        nclk(7);
        chk("reg_on_end", 32'(dc), 32'h40);
        nclk(1);
        chk("reg_off", 32'(dc), 32'h0);

        // fade: dc 0A, step 4
        set_src(1, 24'hABCDEF, 8'h0A, 2'b11, 8'h04);
        req = 3'b010;
        nclk(1);
        chk("fd_grant", 32'(grant), 32'h2);
        nclk(2);
        for (int t = 0; t < 8; t++) begin
            chk($sformatf("fd_lvl%0d", t), 32'(dc), 32'(fade_exp[t]));
            if (t < 7) nclk(4);
        end
        chk("fd_rgb", 32'({red, green, blue}), 32'hABCDEF);

        // same-cycle handover 010 -> 001, then ignored field changes
        req = 3'b001;
        nclk(1);
        chk("ho_grant", 32'(grant), 32'h1);
        set_src(0, 24'h000000, 8'h11, 2'b01, 8'h00);
        nclk(2);
        chk("ho_hold", {red, green, blue, dc}, 32'h1234_5640);

        // reset mid-fade, restart from level 0
        req = 3'b010;
        nclk(10);
        chk("mr_pre", 32'(dc), 32'h08);
        #2 rst_n = 1'b0;
        #1;
        chk("mr_async", {red, green, blue, dc}, 32'h0);
        chk("mr_grant", 32'(grant), 32'h0);
        nclk(1);
        rst_n = 1'b1;
        nclk(1);
        chk("mr_regrant", 32'(grant), 32'h2);
        nclk(2);
        chk("mr_lvl0", 32'(dc), 32'h0);
        nclk(4);
        chk("mr_lvl1", 32'(dc), 32'h04);

        // fade with dc 0 stays at 0; mode OFF gives colour with dc 0
        set_src(2, 24'h010203, 8'h00, 2'b11, 8'h00);
        req = 3'b110;
        nclk(1);
        chk("z_grant", 32'(grant), 32'h4);
        nclk(12);
        chk("z_fade", {red, green, blue, dc}, 32'h0102_0300);
        set_src(0, 24'h0A0B0C, 8'h55, 2'b00, 8'h00);
        req = 3'b001;
        nclk(2);
        chk("off_mode", {red, green, blue, dc}, 32'h0A0B_0C00);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
